// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses, cause codes,
// CSR write/set/clear encoding and the controller state enum.
package trap_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;
  localparam logic [11:0] CsrMip     = 12'h344;

  localparam logic [4:0] CauseIllegal    = 5'd2;
  localparam logic [4:0] CauseLoadFault  = 5'd5;
  localparam logic [4:0] CauseStoreFault = 5'd7;
  localparam logic [4:0] CauseEcallM     = 5'd11;
  localparam logic [4:0] CauseIrqBase    = 5'd16;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned MieIrqLsb   = 16;

  typedef enum logic [1:0] {
    WscNone  = 2'b00,
    WscWrite = 2'b01,
    WscSet   = 2'b10,
    WscClear = 2'b11
  } wsc_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StTrapSave,
    StTrapRedir,
    StMretRedir
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode trap CSRs with combinational read mux, CSR instruction update,
// atomic trap save and mret restore. TRAP_VECTORED_EN makes mtvec[1:0] writable.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_we_i,
  input  logic [11:0]        csr_addr_i,
  input  wsc_mode_e          csr_mode_i,
  input  logic [XLEN-1:0]    csr_operand_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               trap_save_i,
  input  logic [XLEN-1:0]    save_epc_i,
  input  logic [XLEN-1:0]    save_cause_i,
  input  logic [XLEN-1:0]    save_tval_i,
  input  logic               mret_i,
  output logic               mstatus_mie_o,
  output logic [NUM_IRQ-1:0] mie_en_o,
  output logic [XLEN-1:0]    mtvec_o,
  output logic [XLEN-1:0]    mepc_o
);

  localparam logic [XLEN-1:0] LowBitsMask = {{(XLEN-2){1'b1}}, 2'b00};
`ifdef TRAP_VECTORED_EN
  localparam logic [XLEN-1:0] MtvecMask = '1;
`else
  localparam logic [XLEN-1:0] MtvecMask = LowBitsMask;
`endif

  logic               mie_q, mpie_q;
  logic [NUM_IRQ-1:0] mie_en_q;
  logic [XLEN-1:0]    mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0]    rdata, wdata;
  logic               write_en;

  always_comb begin
    rdata = '0;
    case (csr_addr_i)
      CsrMstatus: begin
        rdata[MstatusMie]  = mie_q;
        rdata[MstatusMpie] = mpie_q;
      end
      CsrMie:    rdata[MieIrqLsb +: NUM_IRQ] = mie_en_q;
      CsrMtvec:  rdata = mtvec_q;
      CsrMepc:   rdata = mepc_q & LowBitsMask;
      CsrMcause: rdata = mcause_q;
      CsrMtval:  rdata = mtval_q;
      CsrMip:    rdata[MieIrqLsb +: NUM_IRQ] = irq_i;
      default:   rdata = '0;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not write.
  always_comb begin
    wdata    = rdata;
    write_en = 1'b0;
    unique case (csr_mode_i)
      WscWrite: begin
        wdata    = csr_operand_i;
        write_en = csr_we_i;
      end
      WscSet: begin
        wdata    = rdata | csr_operand_i;
        write_en = csr_we_i && (csr_operand_i != '0);
      end
      WscClear: begin
        wdata    = rdata & ~csr_operand_i;
        write_en = csr_we_i && (csr_operand_i != '0);
      end
      default: write_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mie_en_q <= '0;
      mtvec_q  <= RESET_MTVEC & MtvecMask;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_save_i) begin
      mepc_q   <= save_epc_i;
      mcause_q <= save_cause_i;
      mtval_q  <= save_tval_i;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret_i) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (write_en) begin
      case (csr_addr_i)
        CsrMstatus: begin
          mie_q  <= wdata[MstatusMie];
          mpie_q <= wdata[MstatusMpie];
        end
        CsrMie:    mie_en_q <= wdata[MieIrqLsb +: NUM_IRQ];
        CsrMtvec:  mtvec_q  <= wdata & MtvecMask;
        CsrMepc:   mepc_q   <= wdata;
        CsrMcause: mcause_q <= wdata;
        CsrMtval:  mtval_q  <= wdata;
        default:   ;
      endcase
    end
  end

  assign csr_rdata_o   = rdata;
  assign mstatus_mie_o = mie_q;
  assign mie_en_o      = mie_en_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q & LowBitsMask;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap controller: trap priority, save/redirect sequencing and mret.
// Define TRAP_VECTORED_EN to enable vectored interrupt targets via mtvec mode 01.
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_rw_in,
  input  logic [1:0]         csr_wsc_mode_in,
  input  logic               csr_w_imm_mux,
  input  logic [11:0]        csr_rw_addr_in,
  input  logic [XLEN-1:0]    csr_w_data_reg,
  input  logic [4:0]         csr_w_data_imm,
  output logic [XLEN-1:0]    csr_r_data_out,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               mret,
  input  logic [XLEN-1:0]    fault_addr,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [XLEN-1:0]    epc_cur,
  output logic [XLEN-1:0]    PC_redirect,
  output logic               redirect_mux,
  output logic [3:0]         pipe_flush,
  output logic               RegWrite_cancel,
  output logic               trap_busy
);

  trap_state_e        state_q, state_d;
  logic [XLEN-1:0]    epc_q, cause_q, tval_q;
  logic [XLEN-1:0]    trap_cause, trap_tval, trap_target;
  logic [XLEN-1:0]    csr_operand, csr_rdata, mtvec, mepc;
  logic [NUM_IRQ-1:0] mie_en, irq_pend;
  logic [4:0]         irq_idx;
  logic               mstatus_mie, trap_take, is_idle, csr_we, save_en, mret_en;

  assign is_idle     = (state_q == StIdle);
  assign csr_operand = csr_w_imm_mux ? {{(XLEN-5){1'b0}}, csr_w_data_imm} : csr_w_data_reg;
  assign irq_pend    = {NUM_IRQ{mstatus_mie}} & mie_en & irq_in;

  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_idx = 5'(i);
    end
  end

  always_comb begin
    trap_cause = '0;
    trap_tval  = '0;
    trap_take  = 1'b1;
    if (illegal_inst) begin
      trap_cause[4:0] = CauseIllegal;
    end else if (ecall_m) begin
      trap_cause[4:0] = CauseEcallM;
    end else if (l_access_fault) begin
      trap_cause[4:0] = CauseLoadFault;
      trap_tval       = fault_addr;
    end else if (s_access_fault) begin
      trap_cause[4:0] = CauseStoreFault;
      trap_tval       = fault_addr;
    end else if (|irq_pend) begin
      trap_cause[4:0]    = CauseIrqBase + irq_idx;
      trap_cause[XLEN-1] = 1'b1;
    end else begin
      trap_take = 1'b0;
    end
  end

  // A trap in the same cycle suppresses the CSR instruction.
  assign csr_we         = csr_rw_in && is_idle && !trap_take;
  assign csr_r_data_out = (csr_rw_in && is_idle) ? csr_rdata : '0;

  always_comb begin
`ifdef TRAP_VECTORED_EN
    trap_target = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && cause_q[XLEN-1]) begin
      trap_target = trap_target + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};
    end
`else
    trap_target = mtvec;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      if (is_idle && trap_take) begin
        epc_q   <= epc_cur;
        cause_q <= trap_cause;
        tval_q  <= trap_tval;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    PC_redirect     = '0;
    redirect_mux    = 1'b0;
    pipe_flush      = 4'h0;
    RegWrite_cancel = 1'b0;
    trap_busy       = 1'b1;
    save_en         = 1'b0;
    mret_en         = 1'b0;
    unique case (state_q)
      StIdle: begin
        trap_busy = 1'b0;
        if (trap_take) begin
          RegWrite_cancel = 1'b1;
          pipe_flush      = 4'hF;
          state_d         = StTrapSave;
        end else if (mret) begin
          state_d = StMretRedir;
        end
      end
      StTrapSave: begin
        pipe_flush = 4'hF;
        save_en    = 1'b1;
        state_d    = StTrapRedir;
      end
      StTrapRedir: begin
        redirect_mux = 1'b1;
        pipe_flush   = 4'hF;
        PC_redirect  = trap_target;
        state_d      = StIdle;
      end
      StMretRedir: begin
        redirect_mux = 1'b1;
        pipe_flush   = 4'hF;
        PC_redirect  = mepc;
        mret_en      = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  trap_csr_file #(
    .XLEN        (XLEN),
    .NUM_IRQ     (NUM_IRQ),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr_file (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_we_i      (csr_we),
    .csr_addr_i    (csr_rw_addr_in),
    .csr_mode_i    (wsc_mode_e'(csr_wsc_mode_in)),
    .csr_operand_i (csr_operand),
    .csr_rdata_o   (csr_rdata),
    .irq_i         (irq_in),
    .trap_save_i   (save_en),
    .save_epc_i    (epc_q),
    .save_cause_i  (cause_q),
    .save_tval_i   (tval_q),
    .mret_i        (mret_en),
    .mstatus_mie_o (mstatus_mie),
    .mie_en_o      (mie_en),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc)
  );

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed vectors, a queue-based CSR/trap
// model compared every cycle, and literal expectations from worked examples.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_rw_in, csr_w_imm_mux;
  logic [1:0]  csr_wsc_mode_in;
  logic [11:0] csr_rw_addr_in;
  logic [31:0] csr_w_data_reg;
  logic [4:0]  csr_w_data_imm;
  logic [31:0] csr_r_data_out;
  logic        illegal_inst, ecall_m, l_access_fault, s_access_fault, mret;
  logic [31:0] fault_addr, epc_cur;
  logic [3:0]  irq_in;
  logic [31:0] PC_redirect;
  logic        redirect_mux, RegWrite_cancel, trap_busy;
  logic [3:0]  pipe_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_controller #(
    .XLEN        (32),
    .NUM_IRQ     (4),
    .RESET_MTVEC (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_rw_in       (csr_rw_in),
    .csr_wsc_mode_in (csr_wsc_mode_in),
    .csr_w_imm_mux   (csr_w_imm_mux),
    .csr_rw_addr_in  (csr_rw_addr_in),
    .csr_w_data_reg  (csr_w_data_reg),
    .csr_w_data_imm  (csr_w_data_imm),
    .csr_r_data_out  (csr_r_data_out),
    .illegal_inst    (illegal_inst),
    .ecall_m         (ecall_m),
    .l_access_fault  (l_access_fault),
    .s_access_fault  (s_access_fault),
    .mret            (mret),
    .fault_addr      (fault_addr),
    .irq_in          (irq_in),
    .epc_cur         (epc_cur),
    .PC_redirect     (PC_redirect),
    .redirect_mux    (redirect_mux),
    .pipe_flush      (pipe_flush),
    .RegWrite_cancel (RegWrite_cancel),
    .trap_busy       (trap_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_mie, m_mpie;
  logic [3:0]  m_mien;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

  // One entry per future busy cycle: what the outputs must show, and the CSR effect.
  typedef struct {
    logic        redir;
    logic [31:0] pc;
    logic        save;
    logic        ret;
    logic [31:0] epc, cause, tval;
  } slot_t;
  slot_t sched[$];

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mien = 0;
    m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    sched.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: return 32'(m_mien) << 16;
      12'h305: return m_mtvec;
      12'h341: return m_mepc & ~32'h3;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 32'(irq_in) << 16;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h304: m_mien = v[19:16];
`ifdef TRAP_VECTORED_EN
      12'h305: m_mtvec = v;
`else
      12'h305: m_mtvec = v & ~32'h3;
`endif
      12'h341: m_mepc = v;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_target(input logic [31:0] cause);
    logic [31:0] base = m_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
    if (m_mtvec[1:0] == 2'b01 && cause[31]) return base + 4 * (cause & 32'h1F);
`endif
    return base;
  endfunction

  initial begin
    logic        busy_now, do_trap, do_ret, do_wr, found;
    logic [31:0] cause, tval, op, old, newv;
    logic [3:0]  pend;
    slot_t       s;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("rst_pc", PC_redirect, 0);
        chk("rst_redir", 32'(redirect_mux), 0);
        chk("rst_flush", 32'(pipe_flush), 0);
        chk("rst_cancel", 32'(RegWrite_cancel), 0);
        chk("rst_busy", 32'(trap_busy), 0);
        chk("rst_rdata", csr_r_data_out, 0);
        continue;
      end
      busy_now = sched.size() > 0;
      do_trap = 0; do_ret = 0; do_wr = 0; cause = 0; tval = 0; newv = 0;
      if (busy_now) begin
        s = sched[0];
        chk("busy_flush", 32'(pipe_flush), 32'hF);
        chk("busy_cancel", 32'(RegWrite_cancel), 0);
        chk("busy_busy", 32'(trap_busy), 1);
        chk("busy_redir", 32'(redirect_mux), 32'(s.redir));
        chk("busy_pc", PC_redirect, s.redir ? s.pc : 32'h0);
      end else begin
        pend = irq_in & m_mien & {4{m_mie}};
        do_trap = 1;
        if (illegal_inst) cause = 2;
        else if (ecall_m) cause = 11;
        else if (l_access_fault) begin cause = 5; tval = fault_addr; end
        else if (s_access_fault) begin cause = 7; tval = fault_addr; end
        else begin
          found = 0;
          for (int i = 0; i < 4; i++) begin
            if (pend[i] && !found) begin cause = 32'h8000_0000 | 32'(16 + i); found = 1; end
          end
          do_trap = found;
        end
        do_ret = !do_trap && mret;
        chk("idle_flush", 32'(pipe_flush), do_trap ? 32'hF : 32'h0);
        chk("idle_cancel", 32'(RegWrite_cancel), 32'(do_trap));
        chk("idle_busy", 32'(trap_busy), 0);
        chk("idle_redir", 32'(redirect_mux), 0);
        chk("idle_pc", PC_redirect, 0);
        if (csr_rw_in) begin
          old = m_read(csr_rw_addr_in);
          chk("csr_rdata", csr_r_data_out, old);
          op = csr_w_imm_mux ? 32'(csr_w_data_imm) : csr_w_data_reg;
          case (csr_wsc_mode_in)
            2'b01: begin do_wr = 1; newv = op; end
            2'b10: begin do_wr = op != 0; newv = old | op; end
            2'b11: begin do_wr = op != 0; newv = old & ~op; end
            default: do_wr = 0;
          endcase
          do_wr = do_wr && !do_trap;
        end
      end
      @(posedge clk);
      if (!rst_n) continue;
      if (busy_now) begin
        s = sched.pop_front();
        if (s.save) begin
          m_mepc = s.epc; m_mcause = s.cause; m_mtval = s.tval;
          m_mpie = m_mie; m_mie = 0;
        end
        if (s.ret) begin m_mie = m_mpie; m_mpie = 1; end
      end else if (do_trap) begin
        sched.push_back('{redir: 0, pc: 0, save: 1, ret: 0, epc: epc_cur, cause: cause,
                          tval: tval});
        sched.push_back('{redir: 1, pc: m_target(cause), save: 0, ret: 0, epc: 0, cause: 0,
                          tval: 0});
      end else if (do_ret) begin
        sched.push_back('{redir: 1, pc: m_mepc & ~32'h3, save: 0, ret: 1, epc: 0, cause: 0,
                          tval: 0});
      end else if (do_wr) begin
        m_write(csr_rw_addr_in, newv);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    csr_rw_in = 0; csr_wsc_mode_in = 0; csr_w_imm_mux = 0; csr_rw_addr_in = 0;
    csr_w_data_reg = 0; csr_w_data_imm = 0;
    illegal_inst = 0; ecall_m = 0; l_access_fault = 0; s_access_fault = 0; mret = 0;
    fault_addr = 0; epc_cur = 0; irq_in = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] mode, input logic [11:0] addr, input logic [31:0] data,
                     input logic imm, output logic [31:0] rd);
    csr_rw_in = 1; csr_wsc_mode_in = mode; csr_rw_addr_in = addr;
    csr_w_imm_mux = imm; csr_w_data_reg = data; csr_w_data_imm = data[4:0];
    @(negedge clk);
    rd = csr_r_data_out;
    step();
    clr();
  endtask

  task automatic rd_csr(input logic [11:0] addr, output logic [31:0] rd);
    csr(2'b00, addr, 32'h0, 1'b0, rd);
  endtask

  // Caller has raised the trap inputs; a CSR write during the busy cycle must be ignored.
  task automatic trap_seq(output logic [31:0] pc);
    @(negedge clk);
    step();
    clr();
    csr_rw_in = 1; csr_wsc_mode_in = 2'b01; csr_rw_addr_in = 12'h343; csr_w_data_reg = 32'hDEAD;
    @(negedge clk);
    step();
    clr();
    @(negedge clk);
    pc = PC_redirect;
    step();
  endtask

  task automatic mret_seq(output logic [31:0] pc);
    mret = 1;
    @(negedge clk);
    step();
    clr();
    @(negedge clk);
    pc = PC_redirect;
    step();
  endtask

  initial begin
    logic [31:0] rd, pc, exp_pc;
    clr();
    rst_n = 0;
    repeat (3) step();
    rst_n = 1;
    step();

    rd_csr(12'h305, rd);
    chk("mtvec_reset", rd, 32'h100);
    csr(2'b01, 12'h305, 32'h200, 1'b0, rd);

    // Illegal instruction with a same-cycle CSR write that must be suppressed.
    illegal_inst = 1; epc_cur = 32'h40;
    csr_rw_in = 1; csr_wsc_mode_in = 2'b01; csr_rw_addr_in = 12'h343; csr_w_data_reg = 32'h55;
    trap_seq(pc);
    chk("illegal_pc", pc, 32'h200);
    rd_csr(12'h341, rd); chk("illegal_mepc", rd, 32'h40);
    rd_csr(12'h342, rd); chk("illegal_mcause", rd, 32'h2);
    rd_csr(12'h343, rd); chk("illegal_mtval", rd, 32'h0);

    csr(2'b10, 12'h300, 32'h8, 1'b1, rd);
    l_access_fault = 1; fault_addr = 32'h1234; epc_cur = 32'h80;
    trap_seq(pc);
    chk("lfault_pc", pc, 32'h200);
    rd_csr(12'h342, rd); chk("lfault_mcause", rd, 32'h5);
    rd_csr(12'h343, rd); chk("lfault_mtval", rd, 32'h1234);
    rd_csr(12'h300, rd); chk("lfault_mstatus", rd, 32'h80);

    mret_seq(pc);
    chk("mret_pc", pc, 32'h80);
    rd_csr(12'h300, rd); chk("mret_mstatus", rd, 32'h88);

    // Zero-operand set/clear must not write; mip and unknown addresses ignore writes.
    csr(2'b10, 12'h304, 32'h0, 1'b0, rd);
    rd_csr(12'h304, rd); chk("zero_set_mie", rd, 32'h0);
    csr(2'b11, 12'h300, 32'h0, 1'b1, rd);
    rd_csr(12'h300, rd); chk("zero_clr_mstatus", rd, 32'h88);
    csr(2'b01, 12'h344, 32'hFFFF_FFFF, 1'b0, rd);
    rd_csr(12'h344, rd); chk("mip_ro", rd, 32'h0);
    csr(2'b01, 12'h7C0, 32'h1234_5678, 1'b0, rd);
    rd_csr(12'h7C0, rd); chk("unknown_addr", rd, 32'h0);

    csr(2'b10, 12'h304, 32'h0006_0000, 1'b0, rd);
    rd_csr(12'h304, rd); chk("mie_set", rd, 32'h0006_0000);
    csr(2'b01, 12'h305, 32'h201, 1'b0, rd);
`ifdef TRAP_VECTORED_EN
    exp_pc = 32'h244;
`else
    exp_pc = 32'h200;
    rd_csr(12'h305, rd); chk("mtvec_direct_mask", rd, 32'h200);
`endif
    irq_in = 4'b0110; epc_cur = 32'h100;
    trap_seq(pc);
    chk("irq_pc", pc, exp_pc);
    rd_csr(12'h342, rd); chk("irq_mcause", rd, 32'h8000_0011);

    mret_seq(pc);
    chk("irq_mret_pc", pc, 32'h100);
    rd_csr(12'h300, rd); chk("irq_mret_mstatus", rd, 32'h88);

    // Exception and mret together: exception wins.
    mret = 1; ecall_m = 1; epc_cur = 32'h200;
    trap_seq(pc);
    chk("ecall_pc", pc, 32'h200);
    rd_csr(12'h342, rd); chk("ecall_mcause", rd, 32'd11);
    rd_csr(12'h300, rd); chk("ecall_mstatus", rd, 32'h80);

    // Reset during the save cycle abandons the trap.
    s_access_fault = 1; fault_addr = 32'h99; epc_cur = 32'h300;
    @(negedge clk);
    step();
    clr();
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(trap_busy), 0);
    chk("rst_mid_redir", 32'(redirect_mux), 0);
    step();
    step();
    rst_n = 1;
    step();
    rd_csr(12'h342, rd); chk("rst_mid_mcause", rd, 32'h0);
    rd_csr(12'h305, rd); chk("rst_mid_mtvec", rd, 32'h100);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
